// File: rtl/pp_buff_pkg.sv
// Shared constants and types for the ping-pong tensor buffer.
package pp_buff_pkg;

    localparam int unsigned SWAP_CNT_W   = 16;
    localparam int unsigned READ_LAT_MIN = 1;
    localparam int unsigned READ_LAT_MAX = 2;

    typedef logic bank_t;

    function automatic bit read_lat_ok(input int unsigned lat);
        return (lat >= READ_LAT_MIN) && (lat <= READ_LAT_MAX);
    endfunction

endpackage

// File: rtl/pp_bank_ram.sv
// Single-port byte-enable RAM with a registered read port (read-first on collision).
module pp_bank_ram #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 10
) (
    input  logic                clk_i,
    input  logic                rd_en_i,
    input  logic                wr_en_i,
    input  logic [ADDR_W-1:0]   addr_i,
    input  logic [DATA_W/8-1:0] be_i,
    input  logic [DATA_W-1:0]   wdata_i,
    output logic [DATA_W-1:0]   rdata_o
);

    localparam int unsigned Depth = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_q [Depth];
    logic [DATA_W-1:0] rdata_q;

    // Read data only moves on an issued read, so a stalled pipeline can re-use it.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            for (int i = 0; i < DATA_W / 8; i++) begin
                if (be_i[i]) begin
                    mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
                end
            end
        end
        if (rd_en_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/lwh2f_pingpong_buff.sv
// Two-bank ping-pong buffer: port A (HPS) owns bank[bank_sel], port B owns the other;
// a done/done handshake swaps ownership. Reads are tagged with their bank.
module lwh2f_pingpong_buff
    import pp_buff_pkg::*;
#(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 10,
    parameter int unsigned READ_LAT = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  reset_req,
    input  logic [ADDR_W-1:0]     a_address,
    input  logic                  a_chipselect,
    input  logic                  a_read,
    input  logic                  a_write,
    input  logic [DATA_W/8-1:0]   a_byteenable,
    input  logic [DATA_W-1:0]     a_writedata,
    output logic [DATA_W-1:0]     a_readdata,
    output logic                  a_readdatavalid,
    input  logic [ADDR_W-1:0]     b_address,
    input  logic                  b_chipselect,
    input  logic                  b_read,
    input  logic                  b_write,
    input  logic [DATA_W/8-1:0]   b_byteenable,
    input  logic [DATA_W-1:0]     b_writedata,
    output logic [DATA_W-1:0]     b_readdata,
    output logic                  b_readdatavalid,
    input  logic                  a_done,
    input  logic                  b_done,
    output logic                  bank_sel,
    output logic                  swap,
    output logic [SWAP_CNT_W-1:0] swap_count
);

    localparam int unsigned BeW       = DATA_W / 8;
    localparam bit          UseOutReg = read_lat_ok(READ_LAT) && (READ_LAT == READ_LAT_MAX);

    // Per-port arrays: index 0 is port A, index 1 is port B.
    logic [ADDR_W-1:0] p_addr   [2];
    logic [BeW-1:0]    p_be     [2];
    logic [DATA_W-1:0] p_wdata  [2];
    logic [DATA_W-1:0] ram_rdata[2];
    logic [DATA_W-1:0] st1_data [2];
    logic [DATA_W-1:0] out_data [2];
    logic [DATA_W-1:0] out_q    [2];
    logic [DATA_W-1:0] out_d    [2];
    logic [1:0]        rd_issue, wr_issue, vld_out;

    bank_t                 bank_sel_q, bank_sel_d;
    logic                  a_flag_q, a_flag_d, b_flag_q, b_flag_d;
    logic                  swap_q, swap_d, swap_go;
    logic [SWAP_CNT_W-1:0] swap_cnt_q, swap_cnt_d;
    logic [1:0]            vld1_q, vld1_d, vld2_q, vld2_d;
    bank_t [1:0]           tag1_q, tag1_d;

    assign p_addr[0]  = a_address;
    assign p_addr[1]  = b_address;
    assign p_be[0]    = a_byteenable;
    assign p_be[1]    = b_byteenable;
    assign p_wdata[0] = a_writedata;
    assign p_wdata[1] = b_writedata;

    assign rd_issue = {b_chipselect & b_read,  a_chipselect & a_read}  & {2{~reset_req}};
    assign wr_issue = {b_chipselect & b_write, a_chipselect & a_write} & {2{~reset_req}};

    for (genvar k = 0; k < 2; k++) begin : g_bank
        // Port A owns bank k when bank_sel == k, so the owning port index is bank_sel ^ k.
        bank_t owner;
        assign owner = bank_sel_q ^ bank_t'(k);

        pp_bank_ram #(
            .DATA_W (DATA_W),
            .ADDR_W (ADDR_W)
        ) u_ram (
            .clk_i   (clk),
            .rd_en_i (rd_issue[owner]),
            .wr_en_i (wr_issue[owner]),
            .addr_i  (p_addr[owner]),
            .be_i    (p_be[owner]),
            .wdata_i (p_wdata[owner]),
            .rdata_o (ram_rdata[k])
        );
    end

    always_comb begin
        swap_go    = (a_flag_q | a_done) & (b_flag_q | b_done) & ~reset_req;
        bank_sel_d = bank_sel_q ^ swap_go;
        swap_d     = swap_go;
        swap_cnt_d = swap_cnt_q + SWAP_CNT_W'(swap_go);
        a_flag_d   = a_flag_q;
        b_flag_d   = b_flag_q;
        if (swap_go) begin
            a_flag_d = 1'b0;
            b_flag_d = 1'b0;
        end else if (!reset_req) begin
            a_flag_d = a_flag_q | a_done;
            b_flag_d = b_flag_q | b_done;
        end

        vld1_d = vld1_q;
        vld2_d = vld2_q;
        tag1_d = tag1_q;
        for (int p = 0; p < 2; p++) begin
            st1_data[p] = ram_rdata[tag1_q[p]];
            vld_out[p]  = (UseOutReg ? vld2_q[p] : vld1_q[p]) & ~reset & ~reset_req;
            out_d[p]    = out_q[p];
            if (!reset_req) begin
                vld1_d[p] = rd_issue[p];
                tag1_d[p] = bank_sel_q ^ bank_t'(p);
                vld2_d[p] = vld1_q[p];
            end
            // Without the output register, out_q only remembers the last delivered word.
            if (UseOutReg) begin
                if (!reset_req && vld1_q[p]) begin
                    out_d[p] = st1_data[p];
                end
                out_data[p] = out_q[p];
            end else begin
                if (vld_out[p]) begin
                    out_d[p] = st1_data[p];
                end
                out_data[p] = vld_out[p] ? st1_data[p] : out_q[p];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bank_sel_q <= 1'b0;
            a_flag_q   <= 1'b0;
            b_flag_q   <= 1'b0;
            swap_q     <= 1'b0;
            swap_cnt_q <= '0;
            vld1_q     <= '0;
            vld2_q     <= '0;
            tag1_q     <= '0;
            out_q[0]   <= '0;
            out_q[1]   <= '0;
        end else begin
            bank_sel_q <= bank_sel_d;
            a_flag_q   <= a_flag_d;
            b_flag_q   <= b_flag_d;
            swap_q     <= swap_d;
            swap_cnt_q <= swap_cnt_d;
            vld1_q     <= vld1_d;
            vld2_q     <= vld2_d;
            tag1_q     <= tag1_d;
            out_q[0]   <= out_d[0];
            out_q[1]   <= out_d[1];
        end
    end

    assign a_readdata      = out_data[0];
    assign a_readdatavalid = vld_out[0];
    assign b_readdata      = out_data[1];
    assign b_readdatavalid = vld_out[1];
    assign bank_sel        = bank_sel_q;
    assign swap            = swap_q;
    assign swap_count      = swap_cnt_q;

endmodule

// File: tb/tb_lwh2f_pingpong_buff.sv
// Directed bench: one READ_LAT=1 and one READ_LAT=2 instance driven by the same stimulus.
module tb_lwh2f_pingpong_buff;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, reset_req;
    logic [9:0]  a_address, b_address;
    logic        a_chipselect, a_read, a_write, b_chipselect, b_read, b_write;
    logic [3:0]  a_byteenable, b_byteenable;
    logic [31:0] a_writedata, b_writedata;
    logic        a_done, b_done;

    logic [31:0] a_rd1, b_rd1, a_rd2, b_rd2;
    logic        a_rv1, b_rv1, a_rv2, b_rv2;
    logic        sel1, sel2, swap1, swap2;
    logic [15:0] cnt1, cnt2;

    int n_tests = 0;
    int n_fail  = 0;

    lwh2f_pingpong_buff #(.DATA_W(32), .ADDR_W(10), .READ_LAT(1)) u_dut1 (
        .clk(clk), .reset(reset), .reset_req(reset_req),
        .a_address(a_address), .a_chipselect(a_chipselect), .a_read(a_read),
        .a_write(a_write), .a_byteenable(a_byteenable), .a_writedata(a_writedata),
        .a_readdata(a_rd1), .a_readdatavalid(a_rv1),
        .b_address(b_address), .b_chipselect(b_chipselect), .b_read(b_read),
        .b_write(b_write), .b_byteenable(b_byteenable), .b_writedata(b_writedata),
        .b_readdata(b_rd1), .b_readdatavalid(b_rv1),
        .a_done(a_done), .b_done(b_done),
        .bank_sel(sel1), .swap(swap1), .swap_count(cnt1)
    );

    lwh2f_pingpong_buff #(.DATA_W(32), .ADDR_W(10), .READ_LAT(2)) u_dut2 (
        .clk(clk), .reset(reset), .reset_req(reset_req),
        .a_address(a_address), .a_chipselect(a_chipselect), .a_read(a_read),
        .a_write(a_write), .a_byteenable(a_byteenable), .a_writedata(a_writedata),
        .a_readdata(a_rd2), .a_readdatavalid(a_rv2),
        .b_address(b_address), .b_chipselect(b_chipselect), .b_read(b_read),
        .b_write(b_write), .b_byteenable(b_byteenable), .b_writedata(b_writedata),
        .b_readdata(b_rd2), .b_readdatavalid(b_rv2),
        .a_done(a_done), .b_done(b_done),
        .bank_sel(sel2), .swap(swap2), .swap_count(cnt2)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_port(input bit port, input bit rd, input bit wr, input logic [9:0] addr,
                              input logic [3:0] be, input logic [31:0] wdata);
        if (port) begin
            b_chipselect = rd | wr; b_read = rd; b_write = wr;
            b_address = addr; b_byteenable = be; b_writedata = wdata;
        end else begin
            a_chipselect = rd | wr; a_read = rd; a_write = wr;
            a_address = addr; a_byteenable = be; a_writedata = wdata;
        end
    endtask

    task automatic idle();
        drive_port(1'b0, 1'b0, 1'b0, 10'd0, 4'h0, 32'h0);
        drive_port(1'b1, 1'b0, 1'b0, 10'd0, 4'h0, 32'h0);
        a_done = 1'b0;
        b_done = 1'b0;
    endtask

    task automatic wr(input bit port, input logic [9:0] addr, input logic [3:0] be,
                      input logic [31:0] wdata);
        drive_port(port, 1'b0, 1'b1, addr, be, wdata);
        cyc();
        drive_port(port, 1'b0, 1'b0, 10'd0, 4'h0, 32'h0);
    endtask

    // ne=1 requires the data to differ from exp (for uninitialised RAM contents).
    task automatic rd_chk(input bit port, input logic [9:0] addr, input logic [31:0] exp,
                          input bit ne, input string tag);
        logic [31:0] got;
        drive_port(port, 1'b1, 1'b0, addr, 4'h0, 32'h0);
        cyc();
        check_eq({tag, " lat1 valid"}, 32'(port ? b_rv1 : a_rv1), 32'd1);
        got = port ? b_rd1 : a_rd1;
        check_eq({tag, " lat1 data"}, ne ? 32'(got != exp) : got, ne ? 32'd1 : exp);
        check_eq({tag, " lat2 early valid"}, 32'(port ? b_rv2 : a_rv2), 32'd0);
        drive_port(port, 1'b0, 1'b0, 10'd0, 4'h0, 32'h0);
        cyc();
        check_eq({tag, " lat1 valid drop"}, 32'(port ? b_rv1 : a_rv1), 32'd0);
        check_eq({tag, " lat2 valid"}, 32'(port ? b_rv2 : a_rv2), 32'd1);
        got = port ? b_rd2 : a_rd2;
        check_eq({tag, " lat2 data"}, ne ? 32'(got != exp) : got, ne ? 32'd1 : exp);
    endtask

    task automatic chk_ctl(input bit sel, input bit sw, input logic [15:0] cnt, input string tag);
        check_eq({tag, " bank_sel1"}, 32'(sel1), 32'(sel));
        check_eq({tag, " bank_sel2"}, 32'(sel2), 32'(sel));
        check_eq({tag, " swap1"}, 32'(swap1), 32'(sw));
        check_eq({tag, " swap2"}, 32'(swap2), 32'(sw));
        check_eq({tag, " swap_count1"}, 32'(cnt1), 32'(cnt));
        check_eq({tag, " swap_count2"}, 32'(cnt2), 32'(cnt));
    endtask

    initial begin
        reset = 1'b1;
        reset_req = 1'b0;
        idle();
        repeat (3) cyc();
        reset = 1'b0;
        chk_ctl(1'b0, 1'b0, 16'd0, "reset");
        check_eq("reset a_rv1", 32'(a_rv1), 32'd0);
        check_eq("reset b_rv2", 32'(b_rv2), 32'd0);
        check_eq("reset a_rd1", a_rd1, 32'h0);
        check_eq("reset b_rd2", b_rd2, 32'h0);

        // Basic write/read and bank isolation.
        wr(1'b0, 10'd5, 4'hF, 32'hDEADBEEF);
        rd_chk(1'b0, 10'd5, 32'hDEADBEEF, 1'b0, "A rd5");
        rd_chk(1'b1, 10'd5, 32'hDEADBEEF, 1'b1, "B rd5 other bank");

        // Byte enables.
        wr(1'b0, 10'd7, 4'hF, 32'h11223344);
        wr(1'b0, 10'd7, 4'b0101, 32'hAABBCCDD);
        rd_chk(1'b0, 10'd7, 32'h11BB33DD, 1'b0, "A byte lanes");
        wr(1'b1, 10'd5, 4'hF, 32'h0BADF00D);
        rd_chk(1'b1, 10'd5, 32'h0BADF00D, 1'b0, "B rd5 own bank");

        // Read and write together return the old word.
        drive_port(1'b0, 1'b1, 1'b1, 10'd7, 4'hF, 32'h55555555);
        cyc();
        drive_port(1'b0, 1'b0, 1'b0, 10'd0, 4'h0, 32'h0);
        check_eq("rw same cycle lat1 valid", 32'(a_rv1), 32'd1);
        check_eq("rw same cycle lat1 old", a_rd1, 32'h11BB33DD);
        cyc();
        check_eq("rw same cycle lat2 old", a_rd2, 32'h11BB33DD);
        rd_chk(1'b0, 10'd7, 32'h55555555, 1'b0, "rw new data");

        // a_done then b_done later.
        a_done = 1'b1;
        cyc();
        a_done = 1'b0;
        chk_ctl(1'b0, 1'b0, 16'd0, "a_done only");
        repeat (5) cyc();
        b_done = 1'b1;
        chk_ctl(1'b0, 1'b0, 16'd0, "pre swap");
        cyc();
        b_done = 1'b0;
        chk_ctl(1'b1, 1'b1, 16'd1, "swap1");
        rd_chk(1'b0, 10'd5, 32'h0BADF00D, 1'b0, "A after swap");
        chk_ctl(1'b1, 1'b0, 16'd1, "after swap1");
        rd_chk(1'b1, 10'd5, 32'hDEADBEEF, 1'b0, "B after swap");

        // Simultaneous dones, then a duplicate a_done carried to the next round.
        a_done = 1'b1;
        b_done = 1'b1;
        cyc();
        b_done = 1'b0;
        chk_ctl(1'b0, 1'b1, 16'd2, "dual done");
        cyc();
        a_done = 1'b0;
        chk_ctl(1'b0, 1'b0, 16'd2, "dup no swap");
        repeat (3) cyc();
        chk_ctl(1'b0, 1'b0, 16'd2, "dup idle");
        b_done = 1'b1;
        cyc();
        b_done = 1'b0;
        chk_ctl(1'b1, 1'b1, 16'd3, "dup carried");
        cyc();

        // B reads straddling a swap; A and B write concurrently first.
        drive_port(1'b0, 1'b0, 1'b1, 10'd3, 4'hF, 32'h33331111);
        drive_port(1'b1, 1'b0, 1'b1, 10'd3, 4'hF, 32'h33330000);
        cyc();
        idle();
        a_done = 1'b1;
        cyc();
        a_done = 1'b0;
        drive_port(1'b1, 1'b1, 1'b0, 10'd3, 4'h0, 32'h0);
        b_done = 1'b1;
        cyc();
        b_done = 1'b0;
        chk_ctl(1'b0, 1'b1, 16'd4, "straddle swap");
        check_eq("straddle old lat1 valid", 32'(b_rv1), 32'd1);
        check_eq("straddle old lat1 data", b_rd1, 32'h33330000);
        check_eq("straddle lat2 early", 32'(b_rv2), 32'd0);
        cyc();
        idle();
        check_eq("straddle new lat1 valid", 32'(b_rv1), 32'd1);
        check_eq("straddle new lat1 data", b_rd1, 32'h33331111);
        check_eq("straddle old lat2 valid", 32'(b_rv2), 32'd1);
        check_eq("straddle old lat2 data", b_rd2, 32'h33330000);
        cyc();
        check_eq("straddle lat1 idle", 32'(b_rv1), 32'd0);
        check_eq("straddle lat1 hold", b_rd1, 32'h33331111);
        check_eq("straddle new lat2 valid", 32'(b_rv2), 32'd1);
        check_eq("straddle new lat2 data", b_rd2, 32'h33331111);
        cyc();
        check_eq("straddle lat2 idle", 32'(b_rv2), 32'd0);

        // Freeze with a read in flight, a write pending and a lost a_done.
        drive_port(1'b0, 1'b1, 1'b0, 10'd5, 4'h0, 32'h0);
        cyc();
        drive_port(1'b0, 1'b0, 1'b1, 10'd5, 4'hF, 32'hFFFFFFFF);
        reset_req = 1'b1;
        a_done = 1'b1;
        #1;
        check_eq("freeze lat1 gated", 32'(a_rv1), 32'd0);
        cyc();
        check_eq("freeze c2 lat1", 32'(a_rv1), 32'd0);
        check_eq("freeze c2 lat2", 32'(a_rv2), 32'd0);
        cyc();
        check_eq("freeze c3 lat2", 32'(a_rv2), 32'd0);
        cyc();
        reset_req = 1'b0;
        idle();
        #1;
        check_eq("release lat1 valid", 32'(a_rv1), 32'd1);
        check_eq("release lat1 data", a_rd1, 32'hDEADBEEF);
        check_eq("release lat2 early", 32'(a_rv2), 32'd0);
        cyc();
        check_eq("release lat1 drop", 32'(a_rv1), 32'd0);
        check_eq("release lat2 valid", 32'(a_rv2), 32'd1);
        check_eq("release lat2 data", a_rd2, 32'hDEADBEEF);
        chk_ctl(1'b0, 1'b0, 16'd4, "after freeze");
        rd_chk(1'b0, 10'd5, 32'hDEADBEEF, 1'b0, "frozen write dropped");
        b_done = 1'b1;
        cyc();
        b_done = 1'b0;
        chk_ctl(1'b0, 1'b0, 16'd4, "lost a_done");

        // Reset mid-read (with reset_req also high): valid never asserts, RAM retained.
        a_done = 1'b1;
        cyc();
        a_done = 1'b0;
        chk_ctl(1'b1, 1'b1, 16'd5, "pre-reset swap");
        drive_port(1'b0, 1'b1, 1'b0, 10'd3, 4'h0, 32'h0);
        cyc();
        idle();
        reset = 1'b1;
        reset_req = 1'b1;
        #1;
        check_eq("reset gates lat1 valid", 32'(a_rv1), 32'd0);
        cyc();
        check_eq("in reset lat2 valid", 32'(a_rv2), 32'd0);
        cyc();
        reset = 1'b0;
        reset_req = 1'b0;
        #1;
        chk_ctl(1'b0, 1'b0, 16'd0, "mid-read reset");
        check_eq("mid-read reset lat1 valid", 32'(a_rv1), 32'd0);
        check_eq("mid-read reset lat2 valid", 32'(a_rv2), 32'd0);
        check_eq("mid-read reset lat1 data", a_rd1, 32'h0);
        check_eq("mid-read reset lat2 data", a_rd2, 32'h0);
        cyc();
        check_eq("post reset lat1 valid", 32'(a_rv1), 32'd0);
        check_eq("post reset lat2 valid", 32'(a_rv2), 32'd0);
        rd_chk(1'b0, 10'd5, 32'hDEADBEEF, 1'b0, "retained bank0 addr5");
        rd_chk(1'b0, 10'd7, 32'h55555555, 1'b0, "retained bank0 addr7");
        rd_chk(1'b1, 10'd3, 32'h33331111, 1'b0, "retained bank1 addr3");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/lwh2f_pingpong_buff.md
# lwh2f_pingpong_buff

Parametrised ping-pong tensor buffer between the HPS lightweight bridge (port A) and the accelerator datapath (port B). Holds two banks of 2^ADDR_W words. Each side owns one bank at a time, and a done/done handshake swaps ownership so the HPS fills one tile while the accelerator consumes the other. Reads are pipelined with `readdatavalid`, and the output-register depth is configurable.

## Interface
Parameters:
- DATA_W, 32: word width; a multiple of 8.
- ADDR_W, 10: word-address width per bank; bank depth is 2^ADDR_W.
- READ_LAT, 1: read latency in cycles; legal values 1 or 2 (2 adds an output register).

Ports (all single-bit unless a width is given):
- clk, in: sole clock.
- reset, in: synchronous, active-high.
- reset_req, in: freeze; while high the block holds all state.
- a_address, in, ADDR_W: port A word address.
- a_chipselect, a_read, a_write, in: port A strobes.
- a_byteenable, in, DATA_W/8: port A byte lanes.
- a_writedata, in, DATA_W: port A write data.
- a_readdata, out, DATA_W: port A read data.
- a_readdatavalid, out: port A read data qualifier.
- b_address / b_chipselect / b_read / b_write / b_byteenable / b_writedata / b_readdata / b_readdatavalid: port B, same widths and meaning.
- a_done, in: HPS has finished with its bank (pulse).
- b_done, in: accelerator has finished with its bank (pulse).
- bank_sel, out: bank currently owned by port A; port B owns the other bank.
- swap, out: 1-cycle pulse on the cycle bank_sel changes.
- swap_count, out, 16: number of swaps since reset; wraps at 0xFFFF to 0.

## Operation
- Port A always addresses bank[bank_sel]; port B always addresses bank[~bank_sel]. The two ports never touch the same bank, so there are no collision rules.
- Write: accepted when chipselect & write & ~reset_req. Only lanes with byteenable set are updated. There is no wait-request, so every access is accepted.
- Read: issued when chipselect & read & ~reset_req. a_readdatavalid / b_readdatavalid assert exactly READ_LAT cycles later with the addressed word. A new read can issue every cycle.
- Read and write in the same cycle on the same port: the write takes effect and the read returns the OLD data.
- Each read carries its bank tag through the pipeline. A read issued on the cycle before a swap returns data from the pre-swap bank.
- Handshake: sticky flags a_flag and b_flag are set by a_done and b_done. A done pulse while the corresponding flag is already set is ignored.
- Swap condition: (a_flag|a_done) & (b_flag|b_done) & ~reset_req. On the next edge:
  - bank_sel toggles;
  - both flags clear;
  - swap pulses;
  - swap_count increments.
- Simultaneous a_done and b_done with both flags clear swaps on the next edge.
- Freeze (reset_req=1):
  - writes are dropped;
  - no reads issue;
  - the read pipeline, flags, bank_sel and swap_count hold;
  - readdatavalid is forced low but the pipeline stage holds and re-emits after the freeze;
  - done pulses arriving during the freeze are lost.
- Reset:
  - bank_sel=0, flags=0, swap=0, swap_count=0;
  - readdatavalid=0 on both ports and all in-flight reads are discarded;
  - readdata=0;
  - RAM contents are preserved;
  - reset takes priority over reset_req.

## Timing
- Write visible to a read issued on the following cycle.
- Read latency is READ_LAT for both ports, fixed, and independent of swaps.
- done at cycle N with the other flag set: bank_sel and swap change at edge N+1. An access at N+1 uses the new mapping.
- Port A and port B are fully concurrent, one access each per cycle.
- readdata holds its last value while readdatavalid is low.

## Structure
- Shared package pp_buff_pkg:
  - READ_LAT legality check constant;
  - SWAP_CNT_W=16;
  - bank index type (1 bit).
- Sub-module pp_bank_ram: single-port byte-enable RAM, DATA_W x 2^ADDR_W, synchronous read (1 cycle), intended to infer M10K.
  - Instantiated twice.
  - Each instance's port is muxed from A or B by bank_sel.
- The top level holds the port muxes, the tagged read-valid/tag pipeline (READ_LAT deep), the optional output registers, the handshake flags and swap_count.

## Test plan
- After reset, A writes 0xDEADBEEF to addr 5 with be=4'b1111, then reads addr 5. Required: a_readdatavalid after READ_LAT cycles with 0xDEADBEEF. A B read of addr 5 returns the bank-1 power-on value, not 0xDEADBEEF.
- Write 0x11223344 to addr 7, then write 0xAABBCCDD with be=4'b0101. Required: a read returns 0x11BB33DD.
- a_done at cycle 10, b_done at cycle 20. Required: swap pulse at cycle 21, bank_sel=1, swap_count=1. B now reads 0xDEADBEEF at addr 5, while A sees bank 1.
- a_done and b_done together, followed by a duplicate a_done. Required: exactly one swap; the duplicate sets a_flag for the next round only.
- Back-to-back B reads straddling a swap with READ_LAT=2. Required: the read issued before the swap returns old-bank data and the read after returns new-bank data, with no dropped valids.
- reset_req high for 3 cycles with a read in flight and a write pending. Required: the write is dropped and valid is held off, then the read data is delivered after release. A separate run asserts reset mid-read: valid never asserts, bank_sel=0, and RAM data is retained.
